pixel_compositor: RTL
=====================

# pixel_compositor

Parametrised output stage for the VGA pixel path. Composites N priority-ordered overlay layers (text, graphics, crosshairs, …) onto the processed video pixel with colour-key transparency. Drives the registered pixel to the VGA port. Realigns hsync/vsync/blank through a runtime-selectable delay line, with latency changes applied only at frame boundaries and a flush window covering the switch.

## Interface
Parameters:
- NUM_LAYERS, 2: overlay layer count, ≥1.
- MAX_DLY, 32: longest sync delay in cycles.
- DLY_W, 6: width of latency fields; must hold MAX_DLY.
- KEY_COLOR, 24'hFFFFFF: transparent colour for overlay layers.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- base_pixel  in  24  processed video RGB.
- layer_pixel  in  24*NUM_LAYERS  layer i at [24i+23:24i]; index 0 has highest priority.
- layer_en  in  NUM_LAYERS  per-layer enable.
- layer_half  in  NUM_LAYERS  per-layer half-transparency request. Used only when the configuration macro is set.
- mute  in  1  force black pixel, e.g. during NTSC or PC transfer.
- lat_sel  in  DLY_W  requested sync delay.
- hsync, vsync, blank  in  1 each  raw VGA timing; hsync and vsync are active-low.
- pixel_out  out  24  registered RGB.
- hsync_out, vsync_out, blank_out  out  1 each  delayed timing.
- lat_active  out  DLY_W  delay currently applied.
- flushing  out  1  high during the post-switch flush.

## Operation
**Compositing (combinational, then registered):**
- The winner is the lowest-index layer i where layer_en[i] is set and layer_pixel[i] != KEY_COLOR.
- If no layer qualifies, the output is base_pixel.
- pixel_out is forced to 0 when mute or flushing is high.

**Latency clamp:**
- lat_req = 1 when lat_sel = 0.
- lat_req = MAX_DLY when lat_sel > MAX_DLY.
- Otherwise lat_req = lat_sel.

**Delay line:**
- 3-bit shift register, MAX_DLY deep.
- Output tap is selected by lat_active, so sync_out(t) = sync_in(t − lat_active).

**State machine:**
- RUN: if lat_req != lat_active, go to PEND.
- PEND:
  - If lat_req == lat_active, return to RUN.
  - On a vsync falling edge (vsync registered, previous = 1, current = 0): lat_active ← lat_req, flush counter ← MAX_DLY, go to FLUSH.
- FLUSH:
  - flushing = 1 and blank_out forced to 1.
  - hsync_out and vsync_out come from the new tap.
  - The counter decrements each cycle. At 0, go to RUN, or to PEND if lat_req differs.
  - Changes to lat_sel during FLUSH are not applied until the flush completes.

**Reset (asynchronous):**
- pixel_out = 0, hsync_out = 1, vsync_out = 1, blank_out = 1, flushing = 0.
- lat_active = MAX_DLY, state = RUN.
- All shift stages: hsync and vsync = 1, blank = 1.
- Reset asserted mid-flush aborts the flush immediately.

## Timing
- Pixel latency: 1 cycle from base_pixel/layer_pixel to pixel_out.
- Sync latency: lat_active cycles. Upstream pipeline depth + 1 is supplied on lat_sel.
- A lat_sel change takes effect at the first vsync falling edge after it is seen. It never tears mid-frame.
- flushing asserts on the cycle after the edge and lasts exactly MAX_DLY cycles.
- Simultaneous vsync edge and lat_sel change on the same cycle: the new value is sampled on that cycle and applied.

## Configuration
COMPOSITOR_HALF_ALPHA_EN:
- **Defined:** if the winning layer i has layer_half[i] set, each channel of the output = (layer >> 1) + (base_pixel >> 1), computed per channel in 8 bits with no overflow.
- **Undefined:** layer_half is ignored and the winning layer is opaque.

## Structure
- compositor_pkg holds:
  - state encoding (RUN, PEND, FLUSH);
  - the KEY_COLOR default;
  - the lat_sel clamp function.
- One sub-module, sync_delay_line: parametrised-depth, 3-bit shift register with a runtime tap select and reset values.

## Test plan
- **Reset:** hold reset_n low mid-frame → pixel_out 0, blank_out 1, hsync_out/vsync_out 1, lat_active 32, flushing 0.
- **Fixed delay:** lat_sel = 5, after settle; hsync low at input cycle t → hsync_out low at t+5; blank follows the same delay.
- **Priority:**
  - layer0 = 0xFF0000 and layer1 = 0x0000FF, both enabled, base = 0x123456 → 0xFF0000 next cycle.
  - layer0 = 0xFFFFFF → 0x0000FF.
  - Both layers disabled → 0x123456.
  - mute = 1 → 0x000000.
- **Latency switch:** lat_sel 5 → 9 at mid-line → lat_active stays 5 until the vsync falling edge, then 9. flushing and blank_out are high for 32 cycles, pixel_out is 0 during flush, then state returns to RUN.
- **Clamp and abort:**
  - lat_sel = 0 → lat_active 1.
  - lat_sel = 40 → lat_active 32.
  - lat_sel reverted to the active value while in PEND → no flush.
- **Macro:** layer0 = 0xFF0000 with half set, base = 0x0000FF → 0x7F007F when defined, 0xFF0000 when undefined.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared types and helpers for the pixel compositor:
// latency FSM encoding, default key colour and lat_sel clamp.
package compositor_pkg;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    FLUSH
  } lat_state_e;

  localparam logic [23:0] KEY_COLOR_DEF = 24'hFFFFFF;

  function automatic int unsigned clamp_lat(
    input int unsigned sel,
    input int unsigned max_dly
  );
    int unsigned r;
    r = sel;
    unique case (1'b1)
      (sel == 0):       r = 1;
      (sel > max_dly):  r = max_dly;
      default:          r = sel;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// 3-bit timing shift register with runtime tap select.
// A select of k yields the input delayed by k cycles.
module sync_delay_line
  import compositor_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int SEL_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       d_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [2:0]       q_o
);

  logic [2:0] sr_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) sr_q[k] <= 3'b111;
    end else begin
      sr_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
    end
  end

  always_comb begin
    q_o = sr_q[DEPTH-1];
    for (int k = 0; k < DEPTH; k++) begin
      if (sel_i == SEL_W'(k + 1)) q_o = sr_q[k];
    end
  end

endmodule

// File: rtl/pixel_compositor.sv
// VGA output stage: keyed overlay compositing plus sync realignment.
// Define COMPOSITOR_HALF_ALPHA_EN to enable 50% layer blending.
module pixel_compositor
  import compositor_pkg::*;
#(
  parameter int          NUM_LAYERS = 2,
  parameter int          MAX_DLY    = 32,
  parameter int          DLY_W      = 6,
  parameter logic [23:0] KEY_COLOR  = KEY_COLOR_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [23:0]              base_pixel,
  input  logic [24*NUM_LAYERS-1:0] layer_pixel,
  input  logic [NUM_LAYERS-1:0]    layer_en,
  input  logic [NUM_LAYERS-1:0]    layer_half,
  input  logic                     mute,
  input  logic [DLY_W-1:0]         lat_sel,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic                     blank,
  output logic [23:0]              pixel_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     blank_out,
  output logic [DLY_W-1:0]         lat_active,
  output logic                     flushing
);

  localparam logic [DLY_W-1:0] MAX_L = DLY_W'(MAX_DLY);

  lat_state_e       state_q, state_d;
  logic [DLY_W-1:0] lat_q, lat_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] lat_req;
  logic             vs_q, vs_fall;
  logic [23:0]      pix_q, pix_d;
  logic [23:0]      comp, lyr;
  logic [2:0]       tap;

`ifndef COMPOSITOR_HALF_ALPHA_EN
  logic unused_half;
  assign unused_half = ^layer_half;
`endif

  // Walk from lowest priority upward so layer 0 wins last.
  always_comb begin
    comp = base_pixel;
    lyr  = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      lyr = layer_pixel[24*i +: 24];
      if (layer_en[i] && (lyr != KEY_COLOR)) begin
        comp = lyr;
`ifdef COMPOSITOR_HALF_ALPHA_EN
        if (layer_half[i]) begin
          for (int c = 0; c < 3; c++) begin
            comp[8*c +: 8] = {1'b0, lyr[8*c+1 +: 7]}
                           + {1'b0, base_pixel[8*c+1 +: 7]};
          end
        end
`endif
      end
    end
  end

  assign lat_req = DLY_W'(clamp_lat(32'(lat_sel), MAX_DLY));
  assign vs_fall = vs_q & ~vsync;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (lat_req != lat_q) begin
          if (vs_fall) begin
            lat_d   = lat_req;
            cnt_d   = MAX_L;
            state_d = FLUSH;
          end else begin
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (lat_req == lat_q) begin
          state_d = RUN;
        end else if (vs_fall) begin
          lat_d   = lat_req;
          cnt_d   = MAX_L;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - DLY_W'(1);
        if (cnt_q == DLY_W'(1)) begin
          state_d = (lat_req != lat_q) ? PEND : RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Blank the pixel on the same cycles flushing is visible.
  assign pix_d = (mute || (state_d == FLUSH)) ? 24'h0 : comp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      lat_q   <= MAX_L;
      cnt_q   <= '0;
      vs_q    <= 1'b1;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      vs_q    <= vsync;
      pix_q   <= pix_d;
    end
  end

  sync_delay_line #(
    .DEPTH (MAX_DLY),
    .SEL_W (DLY_W)
  ) u_dly (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    ({hsync, vsync, blank}),
    .sel_i  (lat_q),
    .q_o    (tap)
  );

  assign flushing   = (state_q == FLUSH);
  assign pixel_out  = pix_q;
  assign hsync_out  = tap[2];
  assign vsync_out  = tap[1];
  assign blank_out  = tap[0] | flushing;
  assign lat_active = lat_q;

endmodule
